// File: rtl/as_uart_responder.sv
// Register-access command responder sitting behind a byte UART.
// Decodes 'W' addr data / 'R' addr commands and answers with exactly one byte:
// 'K' for writes, the register value for reads, '?' for rejected commands.

package as_pack;
  localparam int unsigned uart_width = 8;
endpackage

module as_uart_responder
  import as_pack::*;
#(
  parameter int unsigned AW          = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [uart_width-1:0] rx_data_i,
  input  logic                  rx_rdy_i,
  output logic [uart_width-1:0] tx_data_o,
  output logic                  tx_start_o,
  input  logic                  tx_rdy_i,
  output logic [AW-1:0]         reg_addr_o,
  output logic [uart_width-1:0] reg_wdata_o,
  output logic                  reg_we_o,
  input  logic [uart_width-1:0] reg_rdata_i,
  output logic                  err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_ADDR = 3'd1;
  localparam logic [2:0] S_GET_DATA = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_SEND     = 3'd4;
  localparam logic [2:0] S_TX_WAIT  = 3'd5;

  localparam logic [uart_width-1:0] OP_WR   = 8'h57;
  localparam logic [uart_width-1:0] OP_RD   = 8'h52;
  localparam logic [uart_width-1:0] RSP_ACK = 8'h4B;
  localparam logic [uart_width-1:0] RSP_ERR = 8'h3F;

  logic [2:0]            state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [uart_width-1:0] wdata_q, wdata_d;
  logic [uart_width-1:0] tx_data_q, tx_data_d;
  logic                  reg_we_q, reg_we_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            wait_q, wait_d;
  logic                  tx_start_c;
  logic                  addr_bad_c;
  logic                  timeout_c;

  // Address byte is out of range when any bit above the register index is set
  assign addr_bad_c = (rx_data_i >> AW) != '0;
  assign timeout_c  = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    reg_we_d   = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    tx_start_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_rdy_i) begin
          if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
            is_wr_d = (rx_data_i == OP_WR);
            state_d = S_GET_ADDR;
          end else begin
            tx_data_d = RSP_ERR;
            err_d     = 1'b1;
            state_d   = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_rdy_i) begin
          cnt_d  = '0;
          addr_d = rx_data_i[AW-1:0];
          if (addr_bad_c) begin
            tx_data_d = RSP_ERR;
            err_d     = 1'b1;
            state_d   = S_SEND;
          end else if (is_wr_q) begin
            state_d = S_GET_DATA;
          end else begin
            state_d = S_EXEC;
          end
        end else if (timeout_c) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GET_DATA: begin
        if (rx_rdy_i) begin
          cnt_d    = '0;
          wdata_d  = rx_data_i;
          reg_we_d = 1'b1;
          state_d  = S_EXEC;
        end else if (timeout_c) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        if (rx_rdy_i) err_d = 1'b1;
        tx_data_d = is_wr_q ? RSP_ACK : reg_rdata_i;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (rx_rdy_i) err_d = 1'b1;
        if (tx_rdy_i) begin
          tx_start_c = 1'b1;
          wait_d     = 2'd2;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (rx_rdy_i) err_d = 1'b1;
        if (wait_q != 2'd0) begin
          wait_d = wait_q - 2'd1;
        end else if (tx_rdy_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      reg_we_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      reg_we_q  <= reg_we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  // Start must coincide with the cycle the transmitter reports ready
  assign tx_start_o  = tx_start_c;
  assign tx_data_o   = tx_data_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = reg_we_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_as_uart_responder.sv
// Scoreboard bench for as_uart_responder: expected responses and writes are
// queued as commands are sent and popped when the DUT emits them.
module tb_as_uart_responder;

  localparam int unsigned AW   = 4;
  localparam int unsigned TOUT = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_rdy;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic [7:0]    reg_rdata;
  logic          err;

  logic [7:0]    mem [16];
  logic [7:0]    exp_tx [$];
  logic [11:0]   exp_wr [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int byte_cyc = 0;
  int start_count = 0;
  int we_count = 0;
  int err_count = 0;
  int last_start_cyc = -1;
  int last_we_cyc = -1;

  as_uart_responder #(.AW(AW), .TIMEOUT_CYC(TOUT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data),
    .rx_rdy_i   (rx_rdy),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .tx_rdy_i   (tx_rdy),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o   (reg_we),
    .reg_rdata_i(reg_rdata),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign reg_rdata = mem[reg_addr];

  // Output monitor: pops the scoreboard on each response and write
  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [11:0] ew;
    if (rst === 1'b0) begin
      if (tx_start === 1'b1) begin
        start_count++;
        last_start_cyc = cyc;
        checks++;
        if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected got=%h expected=none", tx_data);
        end else begin
          eb = exp_tx.pop_front();
          if (tx_data !== eb) begin
            failures++;
            $display("FAIL tx_data got=%h expected=%h", tx_data, eb);
          end
        end
      end
      if (reg_we === 1'b1) begin
        we_count++;
        last_we_cyc = cyc;
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected got=%h/%h expected=none", reg_addr, reg_wdata);
        end else begin
          ew = exp_wr.pop_front();
          if ({reg_addr, reg_wdata} !== ew) begin
            failures++;
            $display("FAIL wr_payload got=%h expected=%h", {reg_addr, reg_wdata}, ew);
          end
        end
      end
      if (err === 1'b1) err_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_rdy   = 1'b1;
    byte_cyc = cyc;
    @(posedge clk); #1;
    rx_rdy   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_start, reg_we, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes got=%b expected=000", {tx_start, reg_we, err});
    end
    checks++;
    if ({tx_data, reg_wdata, reg_addr} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data got=%h expected=00000", {tx_data, reg_wdata, reg_addr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    int s0, w0, e0;
    s0 = start_count; w0 = we_count; e0 = err_count;
    exp_wr.push_back({4'd3, 8'hA5});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
    idle(10);
    checks++;
    if (last_we_cyc !== byte_cyc + 1 || we_count - w0 !== 1) begin
      failures++;
      $display("FAIL write_we_timing got=cyc%0d/n%0d expected=cyc%0d/n1", last_we_cyc, we_count - w0, byte_cyc + 1);
    end
    checks++;
    if (last_start_cyc !== byte_cyc + 2 || start_count - s0 !== 1) begin
      failures++;
      $display("FAIL write_start_timing got=cyc%0d/n%0d expected=cyc%0d/n1", last_start_cyc, start_count - s0, byte_cyc + 2);
    end
    checks++;
    if (err_count !== e0 || reg_addr !== 4'd3) begin
      failures++;
      $display("FAIL write_err_addr got=err%0d/addr%0d expected=err0/addr3", err_count - e0, reg_addr);
    end
  endtask

  task automatic test_read();
    int s0, w0, e0;
    s0 = start_count; w0 = we_count; e0 = err_count;
    mem[3] = 8'hA5;
    exp_tx.push_back(8'hA5);
    send_byte(8'h52); send_byte(8'h03);
    idle(10);
    checks++;
    if (last_start_cyc !== byte_cyc + 2 || start_count - s0 !== 1) begin
      failures++;
      $display("FAIL read_start_timing got=cyc%0d/n%0d expected=cyc%0d/n1", last_start_cyc, start_count - s0, byte_cyc + 2);
    end
    checks++;
    if (we_count !== w0 || err_count !== e0) begin
      failures++;
      $display("FAIL read_side_effects got=we%0d/err%0d expected=we0/err0", we_count - w0, err_count - e0);
    end
  endtask

  task automatic test_bad_cmd();
    int s0, w0, e0;
    s0 = start_count; w0 = we_count; e0 = err_count;
    exp_tx.push_back(8'h3F);
    send_byte(8'h41);
    idle(10);
    checks++;
    if (err_count - e0 !== 1 || start_count - s0 !== 1) begin
      failures++;
      $display("FAIL bad_opcode got=err%0d/tx%0d expected=err1/tx1", err_count - e0, start_count - s0);
    end
    exp_tx.push_back(8'h3F);
    send_byte(8'h52); send_byte(8'h1F);
    idle(10);
    checks++;
    if (err_count - e0 !== 2 || start_count - s0 !== 2 || we_count !== w0) begin
      failures++;
      $display("FAIL bad_addr got=err%0d/tx%0d/we%0d expected=err2/tx2/we0", err_count - e0, start_count - s0, we_count - w0);
    end
  endtask

  task automatic test_timeout();
    int s0, w0, e0;
    s0 = start_count; w0 = we_count; e0 = err_count;
    send_byte(8'h57); send_byte(8'h02);
    idle(TOUT + 10);
    checks++;
    if (err_count - e0 !== 1 || start_count !== s0 || we_count !== w0) begin
      failures++;
      $display("FAIL timeout got=err%0d/tx%0d/we%0d expected=err1/tx0/we0", err_count - e0, start_count - s0, we_count - w0);
    end
    mem[2] = 8'h5C;
    exp_tx.push_back(8'h5C);
    send_byte(8'h52); send_byte(8'h02);
    idle(10);
    checks++;
    if (start_count - s0 !== 1 || err_count - e0 !== 1) begin
      failures++;
      $display("FAIL after_timeout got=tx%0d/err%0d expected=tx1/err1", start_count - s0, err_count - e0);
    end
    // Slow but in-budget gaps must not trip the timeout
    exp_wr.push_back({4'd2, 8'h11});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); idle(TOUT / 2);
    send_byte(8'h02); idle(TOUT / 2);
    send_byte(8'h11);
    idle(10);
    checks++;
    if (err_count - e0 !== 1 || we_count - w0 !== 1) begin
      failures++;
      $display("FAIL slow_cmd got=err%0d/we%0d expected=err1/we1", err_count - e0, we_count - w0);
    end
  endtask

  task automatic test_back_pressure();
    int s0, e0, rise;
    s0 = start_count; e0 = err_count;
    tx_rdy = 1'b0;
    exp_wr.push_back({4'd1, 8'h77});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h77);
    idle(50);
    checks++;
    if (start_count !== s0) begin
      failures++;
      $display("FAIL held_start got=%0d expected=0", start_count - s0);
    end
    @(posedge clk); #1;
    tx_rdy = 1'b1;
    rise = cyc;
    send_byte(8'h99);
    checks++;
    if (last_start_cyc !== rise || start_count - s0 !== 1) begin
      failures++;
      $display("FAIL release_start got=cyc%0d/n%0d expected=cyc%0d/n1", last_start_cyc, start_count - s0, rise);
    end
    idle(10);
    checks++;
    if (err_count - e0 !== 1 || start_count - s0 !== 1) begin
      failures++;
      $display("FAIL txwait_drop got=err%0d/tx%0d expected=err1/tx1", err_count - e0, start_count - s0);
    end
  endtask

  task automatic test_reset_mid();
    int s0, w0, e0;
    s0 = start_count; w0 = we_count; e0 = err_count;
    send_byte(8'h57); send_byte(8'h05);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_start, reg_we, err, tx_data, reg_wdata, reg_addr} !== 23'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h expected=000000", {tx_start, reg_we, err, tx_data, reg_wdata, reg_addr});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_tx.push_back(8'h3F);
    send_byte(8'hA5);
    idle(10);
    checks++;
    if (err_count - e0 !== 1 || start_count - s0 !== 1 || we_count !== w0) begin
      failures++;
      $display("FAIL after_reset got=err%0d/tx%0d/we%0d expected=err1/tx1/we0", err_count - e0, start_count - s0, we_count - w0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7 + 1);
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_back_pressure();
    test_reset_mid();
    checks++;
    if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=tx%0d/wr%0d expected=tx0/wr0", exp_tx.size(), exp_wr.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/as_uart_responder.md
AS_UART_RESPONDER -- requirements
Module: as_uart_responder

Interface
REQ-001 SHALL have parameter AW, default 4: register address width; 2**AW registers addressable.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000: idle clock cycles allowed between bytes of one command.
REQ-003 SHALL use uart_width from as_pack (8) as the byte width.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 rx_data_i  in  uart_width  received byte from as_uart data_o.
REQ-007 rx_rdy_i  in  1  one-cycle pulse, rx_data_i valid (as_uart rdy_rx_o).
REQ-008 tx_data_o  out  uart_width  response byte to as_uart data_i.
REQ-009 tx_start_o  out  1  one-cycle pulse starting transmission (as_uart start_i).
REQ-010 tx_rdy_i  in  1  transmitter idle (as_uart rdy_tx_o).
REQ-011 reg_addr_o  out  AW  register address.
REQ-012 reg_wdata_o  out  uart_width  register write data.
REQ-013 reg_we_o  out  1  one-cycle register write strobe.
REQ-014 reg_rdata_i  in  uart_width  register read data, combinational from reg_addr_o.
REQ-015 err_o  out  1  one-cycle pulse on bad opcode, bad address, timeout or dropped byte.

Function
REQ-016 Protocol: write = 0x57 ('W'), addr, data -> response 0x4B ('K'); read = 0x52 ('R'), addr -> response = reg_rdata_i.
REQ-017 States: IDLE, GET_ADDR, GET_DATA, EXEC, SEND, TX_WAIT.
REQ-018 IDLE: rx_rdy_i with 0x57 or 0x52 -> latch opcode, go GET_ADDR; any other byte -> load 0x3F ('?'), pulse err_o, go SEND.
REQ-019 GET_ADDR: rx_rdy_i -> latch byte; if bits [7:AW] nonzero -> load 0x3F, pulse err_o, go SEND; else read -> EXEC, write -> GET_DATA.
REQ-020 GET_DATA: rx_rdy_i -> latch data byte, go EXEC.
REQ-021 EXEC (exactly one cycle): write -> reg_we_o=1 with reg_addr_o/reg_wdata_o valid, load 0x4B; read -> sample reg_rdata_i into tx_data_o; go SEND.
REQ-022 reg_addr_o SHALL hold the latched address from the cycle after the address byte until the next address byte.
REQ-023 SEND: when tx_rdy_i=1 pulse tx_start_o for one cycle, tx_data_o stable, go TX_WAIT; else stay.
REQ-024 TX_WAIT: ignore tx_rdy_i for 2 cycles after the start pulse, then return IDLE on first tx_rdy_i=1.
REQ-025 Latency: final command byte pulse at cycle N -> EXEC at N+1 -> tx_start_o at N+2 when tx_rdy_i=1.
REQ-026 Timeout: in GET_ADDR/GET_DATA a counter counts cycles since the last byte; reaching TIMEOUT_CYC -> pulse err_o, return IDLE, no write, no response.
REQ-027 rx_rdy_i during EXEC, SEND or TX_WAIT: byte dropped, err_o pulsed, state unaffected.
REQ-028 rx_rdy_i and timeout expiry in the same cycle: the byte wins, counter clears.
REQ-029 tx_data_o SHALL hold its value from load until the next load.
REQ-030 Exactly one response byte per completed or rejected command; none on timeout.

Reset
REQ-031 rst_i=1 at a clock edge: state IDLE, counter 0, tx_start_o=0, reg_we_o=0, err_o=0, tx_data_o=0, reg_addr_o=0, reg_wdata_o=0.
REQ-032 Reset mid-command SHALL abandon it: no reg_we_o, no tx_start_o afterwards.

Verification
REQ-033 Bytes 0x57,0x03,0xA5 -> one reg_we_o pulse addr=3 wdata=0xA5 the cycle after 0xA5, then tx_start_o with tx_data_o=0x4B.
REQ-034 Bytes 0x52,0x03 with reg_rdata_i=0xA5 -> no reg_we_o, tx_start_o with tx_data_o=0xA5 two cycles after the address byte.
REQ-035 Byte 0x41 -> err_o pulse, response 0x3F; then 0x52,0x1F (AW=4) -> err_o, response 0x3F, no write.
REQ-036 0x57,0x02 then no byte for TIMEOUT_CYC cycles -> err_o pulse, return IDLE, no response; next 0x52,0x02 served normally.
REQ-037 tx_rdy_i held 0 for 50 cycles at SEND -> tx_start_o held 0, fires the cycle tx_rdy_i rises; byte during TX_WAIT -> err_o, dropped.
REQ-038 rst_i asserted after 0x57,0x05 -> all outputs 0 next cycle; following 0xA5 alone -> err_o, response 0x3F.
